cmip_pulse_pacer: RTL and testbench
===================================

Name: cmip_pulse_pacer

Overview:
Single-clock source-domain stage that sits directly upstream of the toggle-based pulse synchronizer. It accepts bursts of single-cycle event pulses that may be back-to-back. It queues them in a pending counter and re-emits them as single-cycle pulses spaced at least GAP cycles apart, so that every event survives the crossing into a slower destination domain. Saturation is reported as a sticky overflow flag.

Parameters:
CNT_W, 8, width of the pending-event counter; max backlog is 2^CNT_W-1.
GAP, 8, cycles from one o_pulse high to the next o_pulse high (minimum 2); integrator sizes it to at least 3 destination clock periods plus margin.

Ports:
i_clk  input  1  source-domain clock
i_rst  input  1  synchronous, active-high reset
i_pulse  input  1  event strobe; every high cycle is one event
i_flush  input  1  discard all pending events
i_ovf_clr  input  1  clear sticky overflow flag
o_pulse  output  1  paced single-cycle event pulse, registered; feeds the synchronizer pulse input
o_pending  output  CNT_W  current backlog, registered
o_busy  output  1  high when FSM is not IDLE or pending is nonzero
o_overflow  output  1  sticky; set when an event arrives while pending is at max
o_drop_cnt  output  16  dropped-event count (see Optional Feature)

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: o_pulse=0, o_pending=0, o_busy=0, o_overflow=0, o_drop_cnt=0, FSM=IDLE, gap counter=0.
- FSM states:
  - IDLE -> FIRE when pending>0 or i_pulse=1.
  - FIRE: o_pulse=1 for exactly one cycle; gap counter loads GAP-2; next state is GAP.
  - GAP -> FIRE when gap counter is 0 and (pending>0 or i_pulse).
  - GAP -> IDLE when gap counter is 0 otherwise.
  - GAP counter decrements every cycle while nonzero.
- Latency: i_pulse in cycle N with FSM in IDLE gives o_pulse high in cycle N+1.
- Under continuous backlog, o_pulse rising edges are exactly GAP cycles apart.
- Pending update per cycle:
  - +1 for i_pulse, -1 for FIRE consuming an event; simultaneous +1/-1 gives net 0.
  - An event arriving in IDLE goes straight to FIRE and is not counted, so o_pending stays 0.
  - Pending never underflows.
- Saturation: i_pulse with pending=max and no simultaneous consume drops the event. pending holds, o_overflow sets next cycle, o_drop_cnt increments.
- i_flush: pending=0 next cycle and any i_pulse in the same cycle is discarded (not counted as a drop). A FIRE already in progress completes and the GAP timer still runs out, so spacing is never violated.
- i_ovf_clr: clears o_overflow. If a drop occurs in the same cycle, set wins.
- Reset mid-GAP or mid-FIRE: returns to IDLE immediately and o_pulse is low on the next cycle.
- o_busy is a registered OR of (FSM!=IDLE) and (pending!=0).

Optional Feature:
- Macro CMIP_PULSE_PACER_DROP_CNT_EN.
- Defined: o_drop_cnt is a 16-bit saturating count of events dropped by saturation, cleared by i_ovf_clr. Increment and clear in the same cycle gives 1.
- Undefined: o_drop_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package cmip_pulse_pkg holds:
  - the FSM state encoding (IDLE, FIRE, GAP, 2 bits);
  - the DROP_CNT_W=16 constant;
  - a localparam check function asserting GAP>=2.
- One natural sub-module: cmip_gap_timer, a loadable down-counter with i_load, i_val and o_zero, instantiated once for the GAP countdown.

Test Plan:
- Single i_pulse at cycle 10 from IDLE -> o_pulse high only at cycle 11; o_pending stays 0; o_busy high cycles 11..11+GAP-1.
- Burst of 5 back-to-back pulses, GAP=8 -> 5 o_pulse at cycles 11,19,27,35,43; o_pending peaks at 4 and reaches 0 by cycle 43.
- CNT_W=3, burst of 10 pulses -> pending saturates at 7; o_overflow set; 8 pulses emitted in total; o_drop_cnt=2 with macro, 0 without; i_ovf_clr then clears both.
- Pending=4 mid-GAP, assert i_flush together with i_pulse -> pending=0 next cycle; no further o_pulse; FSM returns to IDLE when the GAP timer expires.
- i_pulse arriving exactly on the cycle the gap expires with pending=1 -> FIRE proceeds; net pending stays 1; spacing remains exactly GAP.
- Assert i_rst during GAP with pending=3 -> all outputs 0 next cycle; a subsequent single i_pulse behaves as in scenario 1.

Source files
------------

// File: rtl/cmip_pulse_pkg.sv
// Shared definitions for the pulse pacer: FSM encoding, drop-counter width,
// and the elaboration-time GAP sanity check.
package cmip_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 16;

  // FIRE plus at least one GAP cycle is the shortest legal spacing.
  function automatic bit gap_ok(input int gap);
    return gap >= 2;
  endfunction

endpackage

// File: rtl/cmip_gap_timer.sv
// Loadable down-counter that stops at zero; o_zero flags the end of the
// inter-pulse gap.
module cmip_gap_timer #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= i_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_zero = (cnt == '0);

endmodule

// File: rtl/cmip_pulse_pacer.sv
// cmip_pulse_pacer: queues back-to-back event strobes and re-emits them at least GAP cycles apart.
// Build option: define CMIP_PULSE_PACER_DROP_CNT_EN to count saturation drops on o_drop_cnt.
module cmip_pulse_pacer
  import cmip_pulse_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int GAP   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pulse,
  input  logic                  i_flush,
  input  logic                  i_ovf_clr,
  output logic                  o_pulse,
  output logic [CNT_W-1:0]      o_pending,
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  localparam bit GapOk = gap_ok(GAP);
  localparam int TW    = $clog2(GAP);

  if (!GapOk) begin : g_gap_check
    $error("cmip_pulse_pacer: GAP must be at least 2");
  end

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] pending_nx;
  logic             gap_zero;
  logic             inc;
  logic             at_max;
  logic             fire_go;
  logic             drop;

  cmip_gap_timer #(.W(TW)) u_gap_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (state == ST_FIRE),
    .i_val  (TW'(GAP - 2)),
    .o_zero (gap_zero)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    inc     = i_pulse & ~i_flush;
    at_max  = (o_pending == '1);
    // A new FIRE is allowed from IDLE, or once the gap has fully run out.
    fire_go = !i_flush && ((o_pending != '0) || i_pulse) &&
              ((state == ST_IDLE) || ((state == ST_GAP) && gap_zero));
    drop    = inc && at_max && !fire_go;

    pending_nx = o_pending;
    if (i_flush) begin
      pending_nx = '0;
    end else if (inc && !fire_go && !at_max) begin
      pending_nx = o_pending + 1'b1;
    end else if (!inc && fire_go) begin
      pending_nx = o_pending - 1'b1;
    end

    state_nx = state;
    unique case (state)
      ST_IDLE: if (fire_go) state_nx = ST_FIRE;
      ST_FIRE: state_nx = ST_GAP;
      ST_GAP:  if (gap_zero) state_nx = fire_go ? ST_FIRE : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      o_pulse    <= 1'b0;
      o_pending  <= '0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state     <= state_nx;
      o_pulse   <= (state_nx == ST_FIRE);
      o_pending <= pending_nx;
      o_busy    <= (state_nx != ST_IDLE) || (pending_nx != '0);
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        o_overflow <= 1'b0;
      end
    end
  end

`ifdef CMIP_PULSE_PACER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_cnt <= '0;
    end else if (i_ovf_clr) begin
      drop_cnt <= DROP_CNT_W'(drop);
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign o_drop_cnt = drop_cnt;
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cmip_pulse_pacer.sv
// Self-checking bench for cmip_pulse_pacer: expected o_pulse cycles are queued
// when stimulus is driven and matched by a monitor as pulses appear.
module tb_cmip_pulse_pacer;

  localparam int GAP     = 8;
  localparam int CNT_W   = 8;
  localparam int S_GAP   = 12;
  localparam int S_CNT_W = 3;
`ifdef CMIP_PULSE_PACER_DROP_CNT_EN
  localparam int EXP_DROPS = 2;
`else
  localparam int EXP_DROPS = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               pulse, flush, ovf_clr;
  logic               s_pulse, s_ovf_clr;
  logic               m_pulse, m_busy, m_overflow;
  logic [CNT_W-1:0]   m_pending;
  logic [15:0]        m_drop_cnt;
  logic               s_opulse, s_busy, s_overflow;
  logic [S_CNT_W-1:0] s_pending;
  logic [15:0]        s_drop_cnt;

  int cyc    = 0;
  int total  = 0;
  int passed = 0;
  int q_main[$];
  int q_sat[$];

  cmip_pulse_pacer #(.CNT_W(CNT_W), .GAP(GAP)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_pulse    (pulse),
    .i_flush    (flush),
    .i_ovf_clr  (ovf_clr),
    .o_pulse    (m_pulse),
    .o_pending  (m_pending),
    .o_busy     (m_busy),
    .o_overflow (m_overflow),
    .o_drop_cnt (m_drop_cnt)
  );

  cmip_pulse_pacer #(.CNT_W(S_CNT_W), .GAP(S_GAP)) dut_sat (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_pulse    (s_pulse),
    .i_flush    (1'b0),
    .i_ovf_clr  (s_ovf_clr),
    .o_pulse    (s_opulse),
    .o_pending  (s_pending),
    .o_busy     (s_busy),
    .o_overflow (s_overflow),
    .o_drop_cnt (s_drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pulse scoreboards: every o_pulse must match the head of its queue.
  always @(negedge clk) begin
    int e;
    if (q_main.size() > 0 && q_main[0] < cyc) begin
      total++;
      $display("FAIL main_pulse_missing: no pulse by cycle %0d, required at %0d", cyc, q_main[0]);
      void'(q_main.pop_front());
    end
    if (m_pulse === 1'b1) begin
      total++;
      if (q_main.size() == 0) begin
        $display("FAIL main_pulse_unexpected: pulse at cycle %0d, none required", cyc);
      end else begin
        e = q_main.pop_front();
        if (e !== cyc) $display("FAIL main_pulse_time: pulse at cycle %0d, required at %0d", cyc, e);
        else passed++;
      end
    end
    if (q_sat.size() > 0 && q_sat[0] < cyc) begin
      total++;
      $display("FAIL sat_pulse_missing: no pulse by cycle %0d, required at %0d", cyc, q_sat[0]);
      void'(q_sat.pop_front());
    end
    if (s_opulse === 1'b1) begin
      total++;
      if (q_sat.size() == 0) begin
        $display("FAIL sat_pulse_unexpected: pulse at cycle %0d, none required", cyc);
      end else begin
        e = q_sat.pop_front();
        if (e !== cyc) $display("FAIL sat_pulse_time: pulse at cycle %0d, required at %0d", cyc, e);
        else passed++;
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++;
    if ({m_pulse, m_busy, m_overflow, m_pending, m_drop_cnt} !== '0) begin
      $display("FAIL reset_main: outputs %b, required all 0",
               {m_pulse, m_busy, m_overflow, m_pending, m_drop_cnt});
    end else passed++;
    total++;
    if ({s_opulse, s_busy, s_overflow, s_pending, s_drop_cnt} !== '0) begin
      $display("FAIL reset_sat: outputs %b, required all 0",
               {s_opulse, s_busy, s_overflow, s_pending, s_drop_cnt});
    end else passed++;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_single();
    int t0;
    t0 = cyc;
    q_main.push_back(t0 + 1);
    pulse = 1'b1;
    step();
    pulse = 1'b0;
    // busy spans the FIRE cycle and the GAP-1 cycles behind it.
    while (cyc <= t0 + GAP + 1) begin
      total++;
      if (m_busy !== (cyc <= t0 + GAP)) begin
        $display("FAIL single_busy: cycle +%0d busy=%b, required %b", cyc - t0, m_busy, cyc <= t0 + GAP);
      end else passed++;
      total++;
      if (m_pending !== '0) begin
        $display("FAIL single_pending: cycle +%0d pending=%0d, required 0", cyc - t0, m_pending);
      end else passed++;
      step();
    end
    step(3);
  endtask

  task automatic test_burst();
    int t0;
    int peak;
    t0   = cyc;
    peak = 0;
    for (int k = 0; k < 5; k++) q_main.push_back(t0 + 1 + k * GAP);
    pulse = 1'b1;
    while (cyc < t0 + 45) begin
      step();
      pulse = (cyc < t0 + 5);
      if (int'(m_pending) > peak) peak = int'(m_pending);
      if (cyc == t0 + 32) begin
        total++;
        if (m_pending !== CNT_W'(1)) $display("FAIL burst_pending_last: pending=%0d, required 1", m_pending);
        else passed++;
      end
      if (cyc == t0 + 33) begin
        total++;
        if (m_pending !== '0) $display("FAIL burst_pending_drained: pending=%0d, required 0", m_pending);
        else passed++;
      end
    end
    total++;
    if (peak !== 4) $display("FAIL burst_peak: peak pending=%0d, required 4", peak);
    else passed++;
    total++;
    if (q_main.size() !== 0) $display("FAIL burst_leftover: %0d pulses outstanding, required 0", q_main.size());
    else passed++;
  endtask

  task automatic test_flush();
    int t0;
    t0 = cyc;
    q_main.push_back(t0 + 1);
    pulse = 1'b1;
    while (cyc < t0 + 20) begin
      step();
      pulse = (cyc < t0 + 5);
      flush = 1'b0;
      if (cyc == t0 + 5) begin
        total++;
        if (m_pending !== CNT_W'(4)) $display("FAIL flush_pre: pending=%0d, required 4", m_pending);
        else passed++;
        pulse = 1'b1;
        flush = 1'b1;
      end
      if (cyc == t0 + 6) begin
        total++;
        if (m_pending !== '0) $display("FAIL flush_pending: pending=%0d, required 0", m_pending);
        else passed++;
      end
      if (cyc == t0 + 8 || cyc == t0 + 9) begin
        total++;
        if (m_busy !== (cyc == t0 + 8)) begin
          $display("FAIL flush_busy: cycle +%0d busy=%b, required %b", cyc - t0, m_busy, cyc == t0 + 8);
        end else passed++;
      end
    end
    total++;
    if (q_main.size() !== 0) $display("FAIL flush_leftover: %0d pulses outstanding, required 0", q_main.size());
    else passed++;
  endtask

  task automatic test_gap_expiry();
    int t0;
    t0 = cyc;
    q_main.push_back(t0 + 1);
    q_main.push_back(t0 + 1 + GAP);
    q_main.push_back(t0 + 1 + 2 * GAP);
    pulse = 1'b1;
    while (cyc < t0 + 30) begin
      step();
      pulse = (cyc == t0 + 1) || (cyc == t0 + GAP);
      if (cyc == t0 + GAP || cyc == t0 + GAP + 1 || cyc == t0 + 2 * GAP + 1) begin
        total++;
        if (m_pending !== CNT_W'(cyc != t0 + 2 * GAP + 1)) begin
          $display("FAIL gap_expiry_pending: cycle +%0d pending=%0d, required %0d",
                   cyc - t0, m_pending, cyc != t0 + 2 * GAP + 1);
        end else passed++;
      end
    end
    total++;
    if (q_main.size() !== 0) $display("FAIL gap_expiry_leftover: %0d pulses outstanding, required 0", q_main.size());
    else passed++;
  endtask

  task automatic test_saturation();
    int t0;
    t0 = cyc;
    for (int k = 0; k < 8; k++) q_sat.push_back(t0 + 1 + k * S_GAP);
    s_pulse = 1'b1;
    while (cyc < t0 + 100) begin
      step();
      s_pulse = (cyc < t0 + 10);
      if (cyc == t0 + 8 || cyc == t0 + 9) begin
        total++;
        if (s_overflow !== (cyc == t0 + 9)) begin
          $display("FAIL sat_overflow: cycle +%0d overflow=%b, required %b", cyc - t0, s_overflow, cyc == t0 + 9);
        end else passed++;
      end
      if (cyc == t0 + 8 || cyc == t0 + 10) begin
        total++;
        if (s_pending !== 3'd7) $display("FAIL sat_pending: cycle +%0d pending=%0d, required 7", cyc - t0, s_pending);
        else passed++;
      end
      if (cyc == t0 + 10) begin
        total++;
        if (s_drop_cnt !== 16'(EXP_DROPS)) $display("FAIL sat_drop_cnt: drop_cnt=%0d, required %0d", s_drop_cnt, EXP_DROPS);
        else passed++;
      end
    end
    total++;
    if (s_pending !== '0 || s_overflow !== 1'b1) begin
      $display("FAIL sat_drained: pending=%0d overflow=%b, required 0 and 1", s_pending, s_overflow);
    end else passed++;
    total++;
    if (q_sat.size() !== 0) $display("FAIL sat_leftover: %0d pulses outstanding, required 0", q_sat.size());
    else passed++;
    s_ovf_clr = 1'b1;
    step();
    s_ovf_clr = 1'b0;
    total++;
    if (s_overflow !== 1'b0 || s_drop_cnt !== '0) begin
      $display("FAIL sat_clear: overflow=%b drop_cnt=%0d, required 0 and 0", s_overflow, s_drop_cnt);
    end else passed++;
  endtask

  task automatic test_reset_mid_gap();
    int t0;
    t0 = cyc;
    q_main.push_back(t0 + 1);
    pulse = 1'b1;
    while (cyc < t0 + 4) begin
      step();
      pulse = (cyc < t0 + 4);
    end
    total++;
    if (m_pending !== CNT_W'(3)) $display("FAIL rst_gap_pre: pending=%0d, required 3", m_pending);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({m_pulse, m_busy, m_overflow, m_pending, m_drop_cnt} !== '0) begin
      $display("FAIL rst_gap_outputs: outputs %b, required all 0",
               {m_pulse, m_busy, m_overflow, m_pending, m_drop_cnt});
    end else passed++;
    step(3);
    test_single();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    pulse     = 1'b0;
    flush     = 1'b0;
    ovf_clr   = 1'b0;
    s_pulse   = 1'b0;
    s_ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_flush();
    test_gap_expiry();
    test_saturation();
    test_reset_mid_gap();
    step(5);
    total++;
    if (q_main.size() !== 0 || q_sat.size() !== 0) begin
      $display("FAIL final_queues: %0d/%0d pulses outstanding, required 0/0", q_main.size(), q_sat.size());
    end else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
